// File: rtl/byte_word_packer.sv
// Byte-to-word packer: collects a little-endian byte stream into BYTES-wide words on a
// one-deep registered valid/ready output, with flush of a zero-padded partial word.
module byte_word_packer #(
  parameter  int BYTES = 4,
  localparam int CW    = $clog2(BYTES + 1)
) (
  input  logic                 clk_in,
  input  logic                 resetN_in,
  input  logic [7:0]           inputData_in,
  input  logic                 inputValid_in,
  output logic                 inputReady_out,
  input  logic                 flush_in,
  output logic [8*BYTES-1:0]   outputData_out,
  output logic [CW-1:0]        outputCount_out,
  output logic                 outputValid_out,
  input  logic                 outputReady_in,
  output logic [CW-1:0]        fill_out
);

  logic [BYTES-1:0][7:0] accReg;
  logic [CW-1:0]         idx;
  logic                  flushPend;

  logic                  free;
  logic                  acc;
  logic                  take;
  logic [CW-1:0]         n;
  logic                  flushReq;
  logic                  load;
  logic [8*BYTES-1:0]    loadWord;

  assign free           = ~outputValid_out | outputReady_in;
  assign inputReady_out = resetN_in & ((idx != CW'(BYTES - 1)) | free);
  assign acc            = inputValid_in & inputReady_out;
  assign take           = outputValid_out & outputReady_in;
  assign n              = idx + CW'(acc);
  assign flushReq       = flushPend | flush_in;
  // A full word always loads; a partial word loads only on a flush with room downstream.
  assign load           = (n == CW'(BYTES)) | (flushReq & (n != '0) & free);
  assign fill_out       = idx;

  // Word seen by the output register: stored lanes merged with the incoming byte, lanes >= n zeroed.
  generate
    for (genvar gi = 0; gi < BYTES; gi++) begin : gLane
      logic [7:0] laneByte;
      assign laneByte              = (acc && idx == CW'(gi)) ? inputData_in : accReg[gi];
      assign loadWord[8*gi +: 8]   = (CW'(gi) < n) ? laneByte : 8'h00;
    end
  endgenerate

  always_ff @(posedge clk_in or negedge resetN_in) begin
    if (!resetN_in) begin
      accReg          <= '0;
      idx             <= '0;
      flushPend       <= 1'b0;
      outputData_out  <= '0;
      outputCount_out <= '0;
      outputValid_out <= 1'b0;
    end else begin
      if (load) begin
        outputData_out  <= loadWord;
        outputCount_out <= n;
        outputValid_out <= 1'b1;
        accReg          <= '0;
        idx             <= '0;
      end else begin
        if (take)
          outputValid_out <= 1'b0;
        if (acc) begin
          for (int k = 0; k < BYTES; k++)
            if (idx == CW'(k))
              accReg[k] <= inputData_in;
          idx <= n;
        end
      end
      // An empty flush is dropped; a blocked flush stays pending.
      if (load || (flushReq && n == '0))
        flushPend <= 1'b0;
      else if (flush_in)
        flushPend <= 1'b1;
    end
  end

endmodule

// File: tb/tb_byte_word_packer.sv
// Randomized bench for byte_word_packer against a queue-based reference model.
module tb_byte_word_packer;

  localparam int BYTES = 4;
  localparam int CW    = $clog2(BYTES + 1);

  logic                clk_in = 1'b0;
  logic                resetN_in = 1'b0;
  logic [7:0]          inputData_in = '0;
  logic                inputValid_in = 1'b0;
  logic                inputReady_out;
  logic                flush_in = 1'b0;
  logic [8*BYTES-1:0]  outputData_out;
  logic [CW-1:0]       outputCount_out;
  logic                outputValid_out;
  logic                outputReady_in = 1'b0;
  logic [CW-1:0]       fill_out;

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [7:0]          accQ[$];
  bit                  mValid;
  logic [8*BYTES-1:0]  mData;
  int                  mCount;
  bit                  mPend;

  byte_word_packer #(.BYTES(BYTES)) dut (
    .clk_in          (clk_in),
    .resetN_in       (resetN_in),
    .inputData_in    (inputData_in),
    .inputValid_in   (inputValid_in),
    .inputReady_out  (inputReady_out),
    .flush_in        (flush_in),
    .outputData_out  (outputData_out),
    .outputCount_out (outputCount_out),
    .outputValid_out (outputValid_out),
    .outputReady_in  (outputReady_in),
    .fill_out        (fill_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic modelClear();
    accQ.delete();
    mValid = 0;
    mData  = '0;
    mCount = 0;
    mPend  = 0;
  endtask

  task automatic checkOutputs(input string where);
    checkVal({where, "_valid"}, 64'(outputValid_out), 64'(mValid));
    checkVal({where, "_fill"},  64'(fill_out),        64'(accQ.size()));
    if (mValid) begin
      checkVal({where, "_data"},  64'(outputData_out),  64'(mData));
      checkVal({where, "_count"}, 64'(outputCount_out), 64'(mCount));
    end
  endtask

  // One clock cycle: check registered outputs, drive inputs, check ready, advance the model.
  task automatic cycle(input bit v, input logic [7:0] d, input bit r, input bit f);
    bit free, rdy, a, take, freq;
    int n;
    @(negedge clk_in);
    checkOutputs("out");
    inputValid_in  = v;
    inputData_in   = d;
    outputReady_in = r;
    flush_in       = f;
    #1;
    free = !mValid || r;
    rdy  = (accQ.size() != BYTES - 1) || free;
    checkVal("inReady", 64'(inputReady_out), 64'(rdy));
    a    = v && rdy;
    take = mValid && r;
    freq = mPend || f;
    if (a) accQ.push_back(d);
    n = accQ.size();
    if (n == BYTES || (freq && n > 0 && free)) begin
      mData = '0;
      for (int k = 0; k < n; k++) mData[8*k +: 8] = accQ[k];
      mCount = n;
      mValid = 1;
      mPend  = 0;
      accQ.delete();
      $display("word data=%h count=%0d t=%0t", mData, mCount, $time);
    end else begin
      if (take) mValid = 0;
      if (freq && n == 0) mPend = 0;
      else if (f) mPend = 1;
    end
  endtask

  task automatic midReset();
    @(negedge clk_in);
    #2 resetN_in = 1'b0;
    #1;
    checkVal("rst_valid", 64'(outputValid_out), 64'd0);
    checkVal("rst_data",  64'(outputData_out),  64'd0);
    checkVal("rst_count", 64'(outputCount_out), 64'd0);
    checkVal("rst_fill",  64'(fill_out),        64'd0);
    checkVal("rst_ready", 64'(inputReady_out),  64'd0);
    inputValid_in = 0; flush_in = 0; outputReady_in = 0;
    repeat (2) @(negedge clk_in);
    resetN_in = 1'b1;
    modelClear();
    $display("reset released t=%0t", $time);
  endtask

  initial begin
    int vP, rP, fP;
    modelClear();
    #1;
    checkVal("por_valid", 64'(outputValid_out), 64'd0);
    checkVal("por_ready", 64'(inputReady_out),  64'd0);
    repeat (2) @(negedge clk_in);
    resetN_in = 1'b1;

    // Directed: full word, partial flush, empty flush
    cycle(1, 8'h11, 1, 0); cycle(1, 8'h22, 1, 0); cycle(1, 8'h33, 1, 0); cycle(1, 8'h44, 1, 0);
    cycle(0, 8'h00, 1, 0);
    cycle(1, 8'hAA, 1, 0); cycle(1, 8'hBB, 1, 0); cycle(0, 8'h00, 1, 1);
    cycle(0, 8'h00, 1, 0); cycle(0, 8'h00, 1, 1); cycle(0, 8'h00, 1, 0);
    // Flush while output held, one byte joins the pending partial word
    for (int i = 0; i < 4; i++) cycle(1, 8'(8'h50 + i), 0, 0);
    cycle(1, 8'hAA, 0, 0); cycle(1, 8'hBB, 0, 1); cycle(1, 8'hCC, 0, 0);
    cycle(0, 8'h00, 0, 0); cycle(0, 8'h00, 1, 0); cycle(0, 8'h00, 1, 0); cycle(0, 8'h00, 1, 0);
    // Backpressure stall with a full accumulator, then release
    for (int i = 0; i < 8; i++) cycle(1, 8'(i), 0, 0);
    for (int i = 8; i < 16; i++) cycle(1, 8'(i), 1, 0);
    // Reset mid-word with a held output word, then a clean word
    for (int i = 0; i < 6; i++) cycle(1, 8'(8'h60 + i), 0, 0);
    midReset();
    for (int i = 0; i < 4; i++) cycle(1, 8'(8'h70 + i), 1, 0);

    // Randomized phases with varying valid/ready/flush densities
    for (int ph = 0; ph < 5; ph++) begin
      vP = (ph == 0) ? 100 : 30 + 15 * ph;
      rP = (ph == 1) ? 100 : 20 + 18 * ph;
      fP = (ph == 2) ? 25 : 5;
      for (int i = 0; i < 400; i++)
        cycle($urandom_range(99) < vP, 8'($urandom), $urandom_range(99) < rP,
              $urandom_range(99) < fP);
      if (ph == 3) midReset();
    end
    cycle(0, 8'h00, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
